// File: rtl/debounce_scheduler_if.sv
// Switch-side bundle of the debounce scheduler: raw switch levels in,
// press pulses and arbiter status out.
interface debounce_scheduler_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
);
    logic [N-1:0]    sw;
    logic [N-1:0]    one_shot;
    logic            busy;
    logic [ID_W-1:0] active_id;

    modport master (output sw, input one_shot, busy, active_id);
    modport slave  (input sw, output one_shot, busy, active_id);
endinterface

// File: rtl/debounce_scheduler.sv
// N switch channels share one settle timer granted round-robin; one_shot pulses per confirmed press.
// Define DEBOUNCE_RELEASE_EN to also debounce the release of a held (locked) switch.
module debounce_scheduler #(
    parameter int N            = 4,
    parameter int ID_W         = 2,
    parameter int DELAY_CYCLES = 1_500_000,
    parameter int CNT_W        = 21
) (
    input  logic                clk,
    input  logic                rst,
    debounce_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [ID_W-1:0] active_id_reg, active_id_next;
    logic [ID_W-1:0] last_id_reg, last_id_next;
    logic [N-1:0]    s1_reg, s2_reg, s2_d_reg;
    logic [N-1:0]    pending_vec, one_shot_vec;
    logic            check_en;
    logic            found;
    logic [ID_W-1:0] pick;
    logic [ID_W:0]   cand;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            s2_d_reg <= '0;
        end else begin
            s1_reg   <= bus.sw;
            s2_reg   <= s1_reg;
            s2_d_reg <= s2_reg;
        end
    end

    // Round-robin: first pending channel after the last granted one, with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 1; off <= N; off++) begin
            cand = {1'b0, last_id_reg} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(N))
                cand = cand - (ID_W+1)'(N);
            if (!found && pending_vec[cand[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        active_id_next = active_id_reg;
        last_id_next   = last_id_reg;
        check_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    active_id_next = pick;
                    last_id_next   = pick;
                    cnt_next       = '0;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(DELAY_CYCLES - 1))
                    state_next = CHECK;
            end
            CHECK: begin
                check_en   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            active_id_reg <= '0;
            last_id_reg   <= ID_W'(N - 1);
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            active_id_reg <= active_id_next;
            last_id_reg   <= last_id_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic pending_reg, locked_reg, one_shot_reg;
            logic chk_here, rise, pend_set, lock_set, lock_clr, fire;

            assign chk_here = check_en && (active_id_reg == ID_W'(gi));
            assign rise     = s2_reg[gi] & ~s2_d_reg[gi];
`ifdef DEBOUNCE_RELEASE_EN
            logic fall;
            assign fall     = ~s2_reg[gi] & s2_d_reg[gi];
            assign pend_set = (rise & ~locked_reg) | (fall & locked_reg);
            assign lock_clr = chk_here & locked_reg & ~s2_reg[gi];
            assign lock_set = chk_here & ~locked_reg & s2_reg[gi];
            assign fire     = lock_set;
`else
            // A released switch re-arms at once; a rise in the same cycle is not queued.
            assign lock_clr = ~s2_reg[gi];
            assign pend_set = rise & ~locked_reg & ~lock_clr;
            assign lock_set = chk_here & s2_reg[gi];
            assign fire     = lock_set;
`endif

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pending_reg  <= 1'b0;
                    locked_reg   <= 1'b0;
                    one_shot_reg <= 1'b0;
                end else begin
                    // The CHECK clear beats a same-cycle edge on the granted channel.
                    if (chk_here)
                        pending_reg <= 1'b0;
                    else if (pend_set)
                        pending_reg <= 1'b1;
                    if (lock_clr)
                        locked_reg <= 1'b0;
                    else if (lock_set)
                        locked_reg <= 1'b1;
                    one_shot_reg <= fire;
                end
            end

            assign pending_vec[gi]  = pending_reg;
            assign one_shot_vec[gi] = one_shot_reg;
        end
    endgenerate

    assign bus.one_shot  = one_shot_vec;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.active_id = active_id_reg;
endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with a short settle window (DELAY_CYCLES=10, N=4).
module tb_debounce_scheduler;
    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int DELAY = 10;
    localparam int CNT_W = 5;

    logic clk;
    logic rst;

    debounce_scheduler_if #(.N(N), .ID_W(ID_W)) bus ();

    debounce_scheduler #(.N(N), .ID_W(ID_W), .DELAY_CYCLES(DELAY), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    sw;
        logic [N-1:0]    os;
        logic            busy;
        logic [ID_W-1:0] aid;
    } vec_t;

    vec_t tbl[20];
    int   tests = 0;
    int   fails = 0;

    int   t_cur;
    int   pulse_cnt[N];
    int   first_t[N];
    int   busy_cnt;
    int   aid_at3;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_watch();
        t_cur    = 0;
        busy_cnt = 0;
        aid_at3  = -1;
        for (int i = 0; i < N; i++) begin
            pulse_cnt[i] = 0;
            first_t[i]   = -1;
        end
    endtask

    // Drive one sw value, let edge t_cur sample it, then record outputs.
    task automatic step(input logic [N-1:0] swv);
        bus.sw = swv;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (bus.one_shot[i]) begin
                pulse_cnt[i]++;
                if (first_t[i] < 0) first_t[i] = t_cur;
            end
        end
        if (bus.busy) busy_cnt++;
        if (t_cur == 3) aid_at3 = int'(bus.active_id);
        t_cur++;
    endtask

    task automatic apply_table(input string name, input int n);
        for (int t = 0; t < n; t++) begin
            bus.sw = tbl[t].sw;
            @(posedge clk);
            #1;
            tests++;
            if (bus.one_shot !== tbl[t].os || bus.busy !== tbl[t].busy ||
                bus.active_id !== tbl[t].aid) begin
                fails++;
                $display("FAIL %s t=%0d: got os=%b busy=%b aid=%0d expected os=%b busy=%b aid=%0d",
                         name, t, bus.one_shot, bus.busy, bus.active_id,
                         tbl[t].os, tbl[t].busy, tbl[t].aid);
            end else begin
                $display("[TB] %s t=%0d os=%b busy=%b aid=%0d ok", name, t,
                         bus.one_shot, bus.busy, bus.active_id);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0);
    endtask

    initial begin
        rst    = 1'b0;
        bus.sw = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_one_shot", int'(bus.one_shot), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_active_id", int'(bus.active_id), 0);
        rst = 1'b1;
        reset_watch();
        idle(5);
        check("idle_no_activity", busy_cnt + pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);

        // Clean press on sw[2]: busy after edges 3..13, pulse after edge 14.
        for (int t = 0; t < 18; t++) begin
            tbl[t].sw   = 4'b0100;
            tbl[t].os   = (t == 14) ? 4'b0100 : 4'b0000;
            tbl[t].busy = (t >= 3 && t <= 13);
            tbl[t].aid  = (t >= 3) ? 2'd2 : 2'd0;
        end
        apply_table("clean_press_ch2", 18);
        idle(6);

        // sw[2] high 3 cycles only: window runs, CHECK sees 0, no pulse.
        for (int t = 0; t < 17; t++) begin
            tbl[t].sw   = (t < 3) ? 4'b0100 : 4'b0000;
            tbl[t].os   = 4'b0000;
            tbl[t].busy = (t >= 3 && t <= 13);
            tbl[t].aid  = 2'd2;
        end
        apply_table("glitch_ch2", 17);

        // Bouncy press on sw[1], then held: exactly one pulse at t=14.
        reset_watch();
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 4'b0010 : 4'b0000);
        for (int i = 0; i < 130; i++) step(4'b0010);
        $display("[TB] bounce_ch1 pulses=%0d first=%0d", pulse_cnt[1], first_t[1]);
        check("bounce_pulse_count", pulse_cnt[1], 1);
        check("bounce_pulse_time", first_t[1], 14);
        check("bounce_other_pulses", pulse_cnt[0] + pulse_cnt[2] + pulse_cnt[3], 0);
        idle(6);

        // Press sw[0] so last_id becomes 0.
        reset_watch();
        for (int i = 0; i < 20; i++) step(4'b0001);
        $display("[TB] press_ch0 pulses=%0d first=%0d", pulse_cnt[0], first_t[0]);
        check("ch0_pulse_time", first_t[0], 14);
        check("ch0_pulse_count", pulse_cnt[0], 1);
        idle(6);

        // sw[0] and sw[3] together, last_id=0: channel 3 first, channel 0 twelve cycles later.
        reset_watch();
        for (int i = 0; i < 32; i++) step(4'b1001);
        $display("[TB] simul ch3=%0d ch0=%0d aid@3=%0d", first_t[3], first_t[0], aid_at3);
        check("simul_first_grant", aid_at3, 3);
        check("simul_ch3_time", first_t[3], 14);
        check("simul_ch0_time", first_t[0], 26);
        check("simul_counts", pulse_cnt[0] * 10 + pulse_cnt[3], 11);
        idle(6);

        // Reset asserted mid-WAIT on channel 1.
        reset_watch();
        for (int i = 0; i < 6; i++) step(4'b0010);
        check("midwait_busy", int'(bus.busy), 1);
        #2;
        rst = 1'b0;
        #1;
        $display("[TB] async_reset os=%b busy=%b aid=%0d", bus.one_shot, bus.busy, bus.active_id);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_active_id", int'(bus.active_id), 0);
        check("async_rst_one_shot", int'(bus.one_shot), 0);
        bus.sw = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        reset_watch();
        idle(30);
        check("post_rst_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);
        check("post_rst_no_busy", busy_cnt, 0);

`ifdef DEBOUNCE_RELEASE_EN
        // Press, bouncy release (debounced, no pulse), then a fresh press.
        reset_watch();
        for (int i = 0; i < 21; i++) step(4'b1000);
        check("rel_press_time", first_t[3], 14);
        check("rel_press_count", pulse_cnt[3], 1);
        reset_watch();
        for (int i = 0; i < 5; i++) step((i % 2 == 1) ? 4'b1000 : 4'b0000);
        idle(25);
        $display("[TB] release window busy=%0d pulses=%0d", busy_cnt, pulse_cnt[3]);
        check("rel_window_busy", busy_cnt, 11);
        check("rel_window_no_pulse", pulse_cnt[3], 0);
        reset_watch();
        for (int i = 0; i < 20; i++) step(4'b1000);
        check("rel_repress_time", first_t[3], 14);
        check("rel_repress_count", pulse_cnt[3], 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
